mac_axil_arb: RTL and testbench

MAC_AXIL_ARB -- requirements
Module: mac_axil_arb

---
 rtl/mac_ctrl_pkg.sv | 26 ++
 rtl/mac_rr_arb2.sv | 23 ++
 rtl/mac_axil_arb.sv | 185 ++++++++++++++++++
 tb/tb_mac_axil_arb.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_ctrl_pkg.sv
// Shared definitions for the MAC control-path AXI4-Lite arbiter: FSM encoding,
// abort read-data pattern and AXI response codes.
package mac_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_RESP,
    RD_ADDR,
    RD_RESP,
    RESPOND
  } state_e;

  localparam logic [31:0] ABORT_RDATA = 32'hDEADBEEF;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Both error codes have bit 1 set; OKAY/EXOKAY do not.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/mac_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, pointer advances on the
// strobe. After reset the pointer reads "last=1" so requester 0 wins a tie.
module mac_rr_arb2 (
  input  logic       dclk,
  input  logic       sys_reset,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic [1:0] gnt_o
);

  logic last_q;

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) gnt_o = last_q ? 2'b01 : 2'b10;
  end

  always_ff @(posedge dclk or posedge sys_reset) begin
    if (sys_reset)  last_q <= 1'b1;
    else if (adv_i) last_q <= gnt_o[1];
  end

endmodule

// File: rtl/mac_axil_arb.sv
// Arbitrates two simple request ports onto one AXI4-Lite master with a single
// outstanding transaction and a grant-to-response timeout.
module mac_axil_arb
  import mac_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        dclk,
  input  logic        sys_reset,
  input  logic        req0_valid,
  input  logic        req0_write,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_ready,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp0_err,
  input  logic        req1_valid,
  input  logic        req1_write,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_ready,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic        rsp1_err,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready
);

  state_e      state_q, state_d;
  logic        sel_q, sel_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [1:0]  gnt;
  logic        adv;
  logic        tmo;

  mac_rr_arb2 u_arb (
    .dclk      (dclk),
    .sys_reset (sys_reset),
    .req_i     ({req1_valid, req0_valid}),
    .adv_i     (adv),
    .gnt_o     (gnt)
  );

  // The cycle in which the count would reach TIMEOUT_CYCLES is the abort cycle.
  assign tmo = (cnt_q == 32'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    adv       = 1'b0;
    if (state_q != IDLE && state_q != RESPOND) cnt_d = cnt_q + 32'd1;
    case (state_q)
      IDLE: begin
        if (|gnt) begin
          adv       = 1'b1;
          sel_d     = gnt[1];
          addr_d    = gnt[1] ? req1_addr  : req0_addr;
          wdata_d   = gnt[1] ? req1_wdata : req0_wdata;
          cnt_d     = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = (gnt[1] ? req1_write : req0_write) ? WR_ADDR : RD_ADDR;
        end
      end
      WR_ADDR: begin
        if (tmo) begin
          state_d = RESPOND;
          err_d   = 1'b1;
          rdata_d = ABORT_RDATA;
        end else begin
          aw_done_d = aw_done_q | awready;
          w_done_d  = w_done_q | wready;
          if (aw_done_d && w_done_d) state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bvalid) begin
          state_d = RESPOND;
          err_d   = resp_is_err(bresp);
          rdata_d = '0;
        end else if (tmo) begin
          state_d = RESPOND;
          err_d   = 1'b1;
          rdata_d = ABORT_RDATA;
        end
      end
      RD_ADDR: begin
        if (tmo) begin
          state_d = RESPOND;
          err_d   = 1'b1;
          rdata_d = ABORT_RDATA;
        end else if (arready) begin
          state_d = RD_RESP;
        end
      end
      RD_RESP: begin
        if (rvalid) begin
          state_d = RESPOND;
          err_d   = resp_is_err(rresp);
          rdata_d = rdata;
        end else if (tmo) begin
          state_d = RESPOND;
          err_d   = 1'b1;
          rdata_d = ABORT_RDATA;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge dclk or posedge sys_reset) begin
    if (sys_reset) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Every AXI output is a function of registered state only.
  assign req0_ready = (state_q == IDLE) && gnt[0];
  assign req1_ready = (state_q == IDLE) && gnt[1];
  assign rsp0_valid = (state_q == RESPOND) && !sel_q;
  assign rsp1_valid = (state_q == RESPOND) && sel_q;
  assign rsp0_rdata = rdata_q;
  assign rsp1_rdata = rdata_q;
  assign rsp0_err   = err_q;
  assign rsp1_err   = err_q;

  assign awaddr  = addr_q;
  assign araddr  = addr_q;
  assign wdata   = wdata_q;
  assign wstrb   = 4'hF;
  assign awvalid = (state_q == WR_ADDR) && !aw_done_q;
  assign wvalid  = (state_q == WR_ADDR) && !w_done_q;
  assign bready  = (state_q == WR_RESP);
  assign arvalid = (state_q == RD_ADDR);
  assign rready  = (state_q == RD_RESP);

endmodule

// File: tb/tb_mac_axil_arb.sv
// Directed bench for mac_axil_arb: reads, writes in both AW/W orders, tie
// arbitration, error response, timeout abort and mid-transaction reset.
module tb_mac_axil_arb;

  logic        dclk = 1'b0;
  logic        sys_reset;
  logic        req0_valid, req0_write, req0_ready, rsp0_valid, rsp0_err;
  logic [31:0] req0_addr, req0_wdata, rsp0_rdata;
  logic        req1_valid, req1_write, req1_ready, rsp1_valid, rsp1_err;
  logic [31:0] req1_addr, req1_wdata, rsp1_rdata;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 dclk = ~dclk;

  mac_axil_arb #(.TIMEOUT_CYCLES(16)) dut (
    .dclk(dclk), .sys_reset(sys_reset),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
    .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
    .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .wdata(wdata),
    .wstrb(wstrb), .wvalid(wvalid), .wready(wready), .bresp(bresp),
    .bvalid(bvalid), .bready(bready), .araddr(araddr), .arvalid(arvalid),
    .arready(arready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
    .rready(rready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge dclk);
    #1;
  endtask

  initial begin
    sys_reset = 1'b1;
    req0_valid = 0; req0_write = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_write = 0; req1_addr = 0; req1_wdata = 0;
    awready = 0; wready = 0; bresp = 0; bvalid = 0;
    arready = 0; rdata = 0; rresp = 0; rvalid = 0;
    tick(); tick();
    chk("rst_awvalid", 32'(awvalid), 0);
    chk("rst_arvalid", 32'(arvalid), 0);
    chk("rst_bready", 32'(bready), 0);
    chk("rst_rready", 32'(rready), 0);
    chk("rst_rsp0_valid", 32'(rsp0_valid), 0);
    chk("rst_rsp0_rdata", rsp0_rdata, 0);
    chk("rst_awaddr", awaddr, 0);
    sys_reset = 1'b0;
    tick();

    // Read from requester 0
    req0_valid = 1; req0_write = 0; req0_addr = 32'h0000_0400;
    #1;
    chk("rd_req0_ready", 32'(req0_ready), 1);
    chk("rd_req1_ready", 32'(req1_ready), 0);
    tick();
    req0_valid = 0;
    chk("rd_arvalid", 32'(arvalid), 1);
    chk("rd_araddr", araddr, 32'h0000_0400);
    chk("rd_req0_ready_busy", 32'(req0_ready), 0);
    arready = 1;
    tick();
    arready = 0;
    chk("rd_arvalid_drop", 32'(arvalid), 0);
    chk("rd_rready", 32'(rready), 1);
    rvalid = 1; rdata = 32'h1234_5678; rresp = 2'b00;
    tick();
    rvalid = 0; rdata = 0;
    chk("rd_rsp0_valid", 32'(rsp0_valid), 1);
    chk("rd_rsp0_rdata", rsp0_rdata, 32'h1234_5678);
    chk("rd_rsp0_err", 32'(rsp0_err), 0);
    chk("rd_rsp1_valid", 32'(rsp1_valid), 0);
    chk("rd_rready_drop", 32'(rready), 0);
    tick();
    chk("rd_rsp0_pulse_end", 32'(rsp0_valid), 0);
    chk("rd_rdata_held", rsp0_rdata, 32'h1234_5678);
    chk("rd_rsp1_never", 32'(rsp1_valid), 0);

    // Write from requester 1, W handshake before AW
    req1_valid = 1; req1_write = 1; req1_addr = 32'h0000_000C; req1_wdata = 32'h1;
    #1;
    chk("wa_req1_ready", 32'(req1_ready), 1);
    tick();
    req1_valid = 0;
    chk("wa_awvalid", 32'(awvalid), 1);
    chk("wa_wvalid", 32'(wvalid), 1);
    chk("wa_awaddr", awaddr, 32'h0000_000C);
    chk("wa_wdata", wdata, 32'h1);
    chk("wa_wstrb", 32'(wstrb), 32'hF);
    wready = 1;
    tick();
    wready = 0;
    chk("wa_wvalid_drop", 32'(wvalid), 0);
    chk("wa_awvalid_hold", 32'(awvalid), 1);
    chk("wa_bready_early", 32'(bready), 0);
    awready = 1;
    tick();
    awready = 0;
    chk("wa_awvalid_drop", 32'(awvalid), 0);
    chk("wa_bready", 32'(bready), 1);
    tick();
    chk("wa_bready_wait", 32'(bready), 1);
    bvalid = 1; bresp = 2'b00;
    tick();
    bvalid = 0;
    chk("wa_rsp1_valid", 32'(rsp1_valid), 1);
    chk("wa_rsp1_err", 32'(rsp1_err), 0);
    chk("wa_rsp1_rdata", rsp1_rdata, 0);
    chk("wa_rsp0_valid", 32'(rsp0_valid), 0);
    tick();

    // Same request, both handshakes in one cycle, fixed-latency check
    req1_valid = 1; awready = 1; wready = 1;
    #1;
    chk("ws_req1_ready_T", 32'(req1_ready), 1);
    tick();
    req1_valid = 0;
    chk("ws_awvalid_T1", 32'(awvalid), 1);
    chk("ws_wvalid_T1", 32'(wvalid), 1);
    tick();
    chk("ws_awvalid_T2", 32'(awvalid), 0);
    chk("ws_bready_T2", 32'(bready), 1);
    bvalid = 1; bresp = 2'b00;
    tick();
    bvalid = 0; awready = 0; wready = 0;
    chk("ws_rsp1_valid_T3", 32'(rsp1_valid), 1);
    chk("ws_rsp1_err", 32'(rsp1_err), 0);
    tick();

    // Tie: both requesters valid continuously, last grant was requester 1
    req0_valid = 1; req0_write = 0; req0_addr = 32'h100;
    req1_valid = 1; req1_write = 0; req1_addr = 32'h200;
    arready = 1; rvalid = 1; rresp = 2'b00;
    for (int k = 0; k < 4; k++) begin
      rdata = 32'hA0 + 32'(k);
      #1;
      chk("tie_req0_ready", 32'(req0_ready), 32'(k % 2 == 0));
      chk("tie_req1_ready", 32'(req1_ready), 32'(k % 2 == 1));
      tick();
      chk("tie_araddr", araddr, (k % 2 == 0) ? 32'h100 : 32'h200);
      tick();
      tick();
      chk("tie_rsp0_valid", 32'(rsp0_valid), 32'(k % 2 == 0));
      chk("tie_rsp1_valid", 32'(rsp1_valid), 32'(k % 2 == 1));
      chk("tie_rdata", rsp0_rdata, 32'hA0 + 32'(k));
      if (k == 3) begin
        req0_valid = 0; req1_valid = 0; arready = 0; rvalid = 0;
      end
      tick();
    end

    // Slave error on write
    req0_valid = 1; req0_write = 1; req0_addr = 32'h10; req0_wdata = 32'h55;
    awready = 1; wready = 1;
    #1;
    chk("er_req0_ready", 32'(req0_ready), 1);
    tick();
    req0_valid = 0;
    tick();
    awready = 0; wready = 0;
    bvalid = 1; bresp = 2'b10;
    tick();
    bvalid = 0; bresp = 0;
    chk("er_rsp0_valid", 32'(rsp0_valid), 1);
    chk("er_rsp0_err", 32'(rsp0_err), 1);
    chk("er_rsp0_rdata", rsp0_rdata, 0);
    tick();

    // Timeout: arready never comes
    req1_valid = 1; req1_write = 0; req1_addr = 32'h20;
    #1;
    chk("to_req1_ready", 32'(req1_ready), 1);
    tick();
    req1_valid = 0;
    n = 0;
    while (arvalid && n < 40) begin
      n++;
      tick();
    end
    chk("to_arvalid_cycles", 32'(n), 16);
    chk("to_arvalid_drop", 32'(arvalid), 0);
    chk("to_rsp1_valid", 32'(rsp1_valid), 1);
    chk("to_rsp1_err", 32'(rsp1_err), 1);
    chk("to_rsp1_rdata", rsp1_rdata, 32'hDEADBEEF);
    tick();
    chk("to_rsp1_pulse_end", 32'(rsp1_valid), 0);

    // Reset while waiting in WR_RESP
    req0_valid = 1; req0_write = 1; req0_addr = 32'h44; req0_wdata = 32'h77;
    awready = 1; wready = 1;
    tick();
    req0_valid = 0;
    tick();
    awready = 0; wready = 0;
    chk("rs_bready_before", 32'(bready), 1);
    sys_reset = 1;
    #1;
    chk("rs_bready", 32'(bready), 0);
    chk("rs_awaddr", awaddr, 0);
    chk("rs_wdata", wdata, 0);
    chk("rs_rsp0_rdata", rsp0_rdata, 0);
    chk("rs_rsp0_err", 32'(rsp0_err), 0);
    chk("rs_rsp0_valid", 32'(rsp0_valid), 0);
    tick();
    chk("rs_rsp0_valid_hold", 32'(rsp0_valid), 0);
    sys_reset = 0;
    tick();
    chk("rs_rsp0_no_pulse", 32'(rsp0_valid), 0);
    chk("rs_rsp1_no_pulse", 32'(rsp1_valid), 0);
    req0_valid = 1; req0_write = 0; req1_valid = 1; req1_write = 0;
    #1;
    chk("rs_tie_req0_ready", 32'(req0_ready), 1);
    chk("rs_tie_req1_ready", 32'(req1_ready), 0);
    tick();
    req0_valid = 0; req1_valid = 0;
    arready = 1; rvalid = 1;
    tick(); tick();
    arready = 0; rvalid = 0;
    chk("rs_tie_rsp0_valid", 32'(rsp0_valid), 1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
